// File: rtl/ndma_obi_mem_sbr.sv
// ndma_obi_mem_sbr: OBI subordinate backed by a small word-organised register
// memory. Grants after a programmable wait and answers every accepted
// transaction through a fixed-latency, in-order response pipeline.
module ndma_obi_mem_sbr #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          GNT_WAIT  = 0,
    parameter int          RESP_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  GNT_WAIT_C = 4'(GNT_WAIT);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH);

    // Grant state is fully determined by req_i and the wait counter, so it is
    // decoded rather than stored; this keeps gnt_o a same-cycle function of req_i.
    typedef enum logic [1:0] {
        G_IDLE,
        G_WAIT,
        G_GRANT
    } gstate_e;

    gstate_e     gstate;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        accept;

    // Decode grant state and next wait-counter value
    always_comb begin
        gstate = G_IDLE;
        cnt_d  = 4'd0;
        if (!req_i) begin
            // Idle, or a request withdrawn before grant: restart the wait.
            gstate = G_IDLE;
            cnt_d  = 4'd0;
        end else if (cnt_q == GNT_WAIT_C) begin
            // Granting with req_i high is an accept; the next request waits again.
            gstate = G_GRANT;
            cnt_d  = 4'd0;
        end else begin
            gstate = G_WAIT;
            cnt_d  = 4'(cnt_q + 4'd1);
        end
    end

    assign gnt_o  = (gstate == G_GRANT) && !rst_i;
    assign accept = req_i && gnt_o;

    // Wait counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Address decode. The 33-bit difference exposes addresses below the base
    // through its borrow bit, which also keeps the window check wrap-free.
    logic [32:0]   diff;
    logic [31:0]   offset;
    logic          below_base;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign diff       = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign below_base = diff[32];
    assign offset     = diff[31:0];
    assign addr_err   = (addr_i[1:0] != 2'b00) || below_base || (offset >= SPAN_BYTES);
    assign idx        = offset[AW+1:2];

    // Byte-enable expansion into a bit mask for the read-modify-write merge
    logic [31:0] be_mask;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign be_mask[8*gi +: 8] = {8{be_i[gi]}};
        end
    endgenerate

    logic [31:0] mem_q [DEPTH];
    logic        wr_en;
    logic [31:0] rd_word;

    assign wr_en   = accept && we_i && !addr_err;
    // Writes and errors return zero data; reads see everything written on earlier edges.
    assign rd_word = (!we_i && !addr_err) ? mem_q[idx] : 32'd0;

    // Memory array: cleared by reset, byte-masked write on accepted good writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= (mem_q[idx] & ~be_mask) | (wdata_i & be_mask);
        end
    end

    // Response pipeline: stage 0 is loaded at the accept edge, the last stage
    // drives the outputs. Empty slots carry zero data so the outputs read 0
    // whenever rvalid_o is low.
    logic [RESP_LAT-1:0] pv_q;
    logic [RESP_LAT-1:0] perr_q;
    logic [31:0]         pdata_q [RESP_LAT];

    // Shift the response pipeline one stage per clock; reset drops all in-flight responses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pv_q   <= '0;
            perr_q <= '0;
            for (int s = 0; s < RESP_LAT; s++) begin
                pdata_q[s] <= 32'd0;
            end
        end else begin
            pv_q[0]    <= accept;
            perr_q[0]  <= accept && addr_err;
            pdata_q[0] <= accept ? rd_word : 32'd0;
            for (int s = 1; s < RESP_LAT; s++) begin
                pv_q[s]    <= pv_q[s-1];
                perr_q[s]  <= perr_q[s-1];
                pdata_q[s] <= pdata_q[s-1];
            end
        end
    end

    assign rvalid_o = pv_q[RESP_LAT-1];
    assign err_o    = perr_q[RESP_LAT-1];
    assign rdata_o  = pdata_q[RESP_LAT-1];

endmodule
